// File: rtl/bist_multi_engine_pkg.sv
// rtl/bist_multi_engine_pkg.sv - shared encodings for the multi-channel BIST engine
//
// Purpose: MODE and ERR_CODE encodings, FSM state constants and width helpers
//          shared by bist_multi_engine and bist_vec_mem.
// Ports:   none (package).
package bist_multi_engine_pkg;

  // Test pattern source selected by BIST_CONF_REG[MODE]
  localparam logic [1:0] MODE_COUNTER = 2'b00;
  localparam logic [1:0] MODE_WALK    = 2'b01;
  localparam logic [1:0] MODE_USER    = 2'b10;
  localparam logic [1:0] MODE_ILLEGAL = 2'b11;

  // Result reported on err_code
  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISMATCH = 2'd1;
  localparam logic [1:0] ERR_BAD_CONF = 2'd2;
  localparam logic [1:0] ERR_ABORT    = 2'd3;

  // Sequencer states
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARM   = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // clog2 with a floor of 1 so single-entry address/index ports keep a bit
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bist_vec_mem.sv
// rtl/bist_vec_mem.sv - user vector memory, one write port and one registered read port
//
// Purpose: holds {EXP, STIM} user vectors. Contents are not reset.
// Ports:   clk               clock
//          wr_en/wr_addr/wr_data  write port, takes effect after the edge
//          rd_addr/rd_data   read port, data valid one cycle after the address
module bist_vec_mem
  import bist_multi_engine_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int W     = 16,
  localparam int AW   = clog2_min1(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < DEPTH)) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/bist_multi_engine.sv
// rtl/bist_multi_engine.sv - multi-channel BIST sequencer with response checking
//
// Purpose: on an enable rising edge, drives LEN stimulus vectors (counter,
//          walking-one or user memory) to a DUT, compares its responses LAT
//          cycles later on the masked channels and reports pass/fail with a
//          first-failure capture and a saturating failing-vector count.
// Ports:   clk, rst_n                   clock, async active-low reset
//          enable                       rising edge starts, low aborts
//          bist_conf_reg                {MODE, CH_MASK, LEN}
//          user_we/user_addr/user_data  user vector write {EXP, STIM}
//          dut_stim/dut_valid           stimulus to the DUT
//          dut_resp                     DUT response, LAT cycles after valid
//          busy/done/pass               status
//          err_code/err_idx/err_ch/err_exp/err_got/err_count  result capture
module bist_multi_engine
  import bist_multi_engine_pkg::*;
#(
  parameter int DW     = 4,
  parameter int NCH    = 2,
  parameter int MAXLEN = 256,
  parameter int LAT    = 1,
  localparam int LW    = $clog2(MAXLEN + 1),
  localparam int AW    = clog2_min1(MAXLEN),
  localparam int CW    = clog2_min1(NCH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [2+NCH+LW-1:0] bist_conf_reg,
  input  logic                user_we,
  input  logic [AW-1:0]       user_addr,
  input  logic [2*NCH*DW-1:0] user_data,
  output logic [NCH*DW-1:0]   dut_stim,
  output logic                dut_valid,
  input  logic [NCH*DW-1:0]   dut_resp,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [1:0]          err_code,
  output logic [LW-1:0]       err_idx,
  output logic [CW-1:0]       err_ch,
  output logic [DW-1:0]       err_exp,
  output logic [DW-1:0]       err_got,
  output logic [15:0]         err_count
);

  logic [2:0]      state;
  logic            en_q;
  logic [LW-1:0]   k;
  logic [3:0]      dcnt;
  logic [1:0]      mode_q;
  logic [NCH-1:0]  mask_q;
  logic [LW-1:0]   len_q;

  // Expected-value delay line; the compare happens at the last stage
  logic [LAT-1:0]                 dl_v;
  logic [LAT-1:0][NCH*DW-1:0]     dl_exp;
  logic [LAT-1:0][LW-1:0]         dl_idx;

  logic [2*NCH*DW-1:0] rd_data;
  logic [AW-1:0]       rd_addr;
  logic [NCH*DW-1:0]   gen_stim, stim_vec, exp_vec;
  logic                fail_any;
  logic [CW-1:0]       fail_ch;
  logic [DW-1:0]       fail_exp, fail_got;

  wire [1:0]     conf_mode = bist_conf_reg[LW+NCH +: 2];
  wire [NCH-1:0] conf_mask = bist_conf_reg[LW +: NCH];
  wire [LW-1:0]  conf_len  = bist_conf_reg[LW-1:0];
  wire conf_bad = (conf_len == '0) || (32'(conf_len) > MAXLEN) ||
                  (conf_mode == MODE_ILLEGAL) || (conf_mask == '0);

  wire start    = enable && !en_q;
  wire abort    = busy && !enable;
  // Responses arriving in the abort cycle are discarded
  wire cmp_fire = dl_v[LAT-1] && !abort;

  assign busy      = (state == ST_ARM) || (state == ST_RUN) || (state == ST_DRAIN);
  assign done      = (state == ST_DONE);
  assign pass      = done && (err_code == ERR_NONE);
  // Combinational on enable so an abort drops valid in the same cycle
  assign dut_valid = (state == ST_RUN) && enable;
  assign dut_stim  = dut_valid ? stim_vec : '0;

  // Read-ahead: ARM fetches entry 0, RUN cycle k fetches entry k+1
  assign rd_addr = (state == ST_RUN) ? AW'(32'(k) + 1) : '0;

  bist_vec_mem #(.DEPTH(MAXLEN), .W(2*NCH*DW)) u_vec_mem (
    .clk     (clk),
    .wr_en   (user_we && !busy),
    .wr_addr (user_addr),
    .wr_data (user_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_comb begin
    gen_stim = '0;
    for (int c = 0; c < NCH; c++) begin
      if (mode_q == MODE_WALK)
        gen_stim[c*DW +: DW] = DW'(1) << ((32'(k) + 32'(c)) % DW);
      else
        gen_stim[c*DW +: DW] = DW'(k) + DW'(c);
    end
    if (mode_q == MODE_USER) begin
      stim_vec = rd_data[NCH*DW-1:0];
      exp_vec  = rd_data[2*NCH*DW-1:NCH*DW];
    end else begin
      stim_vec = gen_stim;
      exp_vec  = gen_stim;
    end
  end

  // Scan downwards so the lowest failing enabled channel wins
  always_comb begin
    fail_any = 1'b0;
    fail_ch  = '0;
    fail_exp = '0;
    fail_got = '0;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (mask_q[c] && (dut_resp[c*DW +: DW] != dl_exp[LAT-1][c*DW +: DW])) begin
        fail_any = 1'b1;
        fail_ch  = CW'(c);
        fail_exp = dl_exp[LAT-1][c*DW +: DW];
        fail_got = dut_resp[c*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      en_q      <= 1'b1;
      k         <= '0;
      dcnt      <= '0;
      mode_q    <= '0;
      mask_q    <= '0;
      len_q     <= '0;
      dl_v      <= '0;
      dl_exp    <= '0;
      dl_idx    <= '0;
      err_code  <= ERR_NONE;
      err_idx   <= '0;
      err_ch    <= '0;
      err_exp   <= '0;
      err_got   <= '0;
      err_count <= '0;
    end else begin
      en_q <= enable;

      for (int i = LAT - 1; i > 0; i--) begin
        dl_v[i]   <= dl_v[i-1];
        dl_exp[i] <= dl_exp[i-1];
        dl_idx[i] <= dl_idx[i-1];
      end
      dl_v[0]   <= dut_valid;
      dl_exp[0] <= exp_vec;
      dl_idx[0] <= k;

      if (cmp_fire && fail_any) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        if (err_code == ERR_NONE) begin
          err_code <= ERR_MISMATCH;
          err_idx  <= dl_idx[LAT-1];
          err_ch   <= fail_ch;
          err_exp  <= fail_exp;
          err_got  <= fail_got;
        end
      end

      if (abort) begin
        // Later assignment overrides any mismatch code and flushes the line
        state    <= ST_DONE;
        err_code <= ERR_ABORT;
        dl_v     <= '0;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              state     <= ST_ARM;
              err_code  <= ERR_NONE;
              err_idx   <= '0;
              err_ch    <= '0;
              err_exp   <= '0;
              err_got   <= '0;
              err_count <= '0;
            end
          end
          ST_ARM: begin
            mode_q <= conf_mode;
            mask_q <= conf_mask;
            len_q  <= conf_len;
            k      <= '0;
            if (conf_bad) begin
              state    <= ST_DONE;
              err_code <= ERR_BAD_CONF;
            end else begin
              state <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (k == len_q - LW'(1)) begin
              state <= ST_DRAIN;
              dcnt  <= '0;
            end else begin
              k <= k + LW'(1);
            end
          end
          ST_DRAIN: begin
            if (dcnt == 4'(LAT - 1)) state <= ST_DONE;
            else                     dcnt  <= dcnt + 4'd1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/bist_multi_engine.md
BIST_MULTI_ENGINE -- requirements
Module: bist_multi_engine

Interface
REQ-001 Parameter DW, default 4: data width per channel, 1..16.
REQ-002 Parameter NCH, default 2: channel count, 1..8.
REQ-003 Parameter MAXLEN, default 256: max vectors per test and user-memory depth; LW = clog2(MAXLEN+1).
REQ-004 Parameter LAT, default 1: DUT response latency in cycles, 1..8.
REQ-005 CLK  input  1  single clock, all logic rising-edge.
REQ-006 RST_N  input  1  asynchronous, active-low reset.
REQ-007 ENABLE  input  1  low-to-high edge starts a test; low during a test aborts it.
REQ-008 BIST_CONF_REG  input  2+NCH+LW  {MODE[1:0], CH_MASK[NCH-1:0], LEN[LW-1:0]}; MODE 00 counter, 01 walking-one, 10 user, 11 illegal.
REQ-009 USER_WE / USER_ADDR / USER_DATA  input  1 / clog2(MAXLEN) / 2*NCH*DW  user-vector write {EXP, STIM}.
REQ-010 DUT_STIM / DUT_VALID  output  NCH*DW / 1  stimulus to DUT, channel c at bits [c*DW +: DW].
REQ-011 DUT_RESP  input  NCH*DW  DUT response, valid LAT cycles after matching DUT_VALID.
REQ-012 BUSY, DONE, PASS  output  1 each  status flags.
REQ-013 ERR_CODE  output  2  0 none, 1 mismatch, 2 bad config, 3 aborted.
REQ-014 ERR_IDX / ERR_CH / ERR_EXP / ERR_GOT  output  LW / clog2(NCH) / DW / DW  first-failure capture.
REQ-015 ERR_COUNT  output  16  failing-vector count, saturating at 16'hFFFF.

Function
REQ-016 FSM states IDLE, ARM, RUN, DRAIN, DONE; start edge accepted only in IDLE or DONE, moving to ARM.
REQ-017 On start, all ERR_* outputs, PASS and DONE clear; BUSY goes high and stays high through ARM, RUN and DRAIN.
REQ-018 ARM lasts 1 cycle and latches BIST_CONF_REG; the config is bad if LEN = 0, LEN > MAXLEN, MODE = 11, or CH_MASK = 0.
REQ-019 Bad config goes ARM->DONE with ERR_CODE=2 and PASS=0; DUT_VALID never asserts.
REQ-020 RUN lasts exactly LEN cycles: vector k (0..LEN-1) is driven on RUN cycle k with DUT_VALID=1.
REQ-021 Counter mode: channel c, vector k stimulus = (k+c) mod 2^DW; expected = stimulus (loopback).
REQ-022 Walking-one mode: channel c, vector k stimulus = 1 << ((k+c) mod DW); expected = stimulus.
REQ-023 User mode: vector k STIM/EXP are read from user memory entry k; memory is read-ahead so there are no bubbles.
REQ-024 The expected value and valid travel through a LAT-stage delay line; DUT_RESP is compared on the cycle the delayed valid is high.
REQ-025 Only channels with CH_MASK[c]=1 are compared; masked-off channels never count as errors.
REQ-026 A vector fails if any enabled channel mismatches; ERR_COUNT increments by 1 per failing vector.
REQ-027 On the first failing vector, capture ERR_IDX=k, ERR_CH=lowest failing channel, ERR_EXP and ERR_GOT of that channel, and set ERR_CODE=1; later failures do not overwrite the capture.
REQ-028 DRAIN lasts LAT cycles after the last RUN cycle, then the FSM goes to DONE: BUSY=0, DONE=1, PASS=(ERR_CODE==0).
REQ-029 Total BUSY time = 1+LEN+LAT cycles; the bad-config case gives 1 cycle.
REQ-030 ENABLE low in ARM, RUN or DRAIN aborts:
- next state is DONE, ERR_CODE=3 (overrides mismatch), PASS=0;
- DUT_VALID drops the same cycle;
- in-flight responses are discarded.
REQ-031 USER_WE writes are ignored while BUSY=1; writes in other states take effect the next cycle.
REQ-032 DONE holds until the next start edge or reset.
REQ-033 DUT_STIM = 0 whenever DUT_VALID = 0.

Reset
REQ-034 RST_N low forces IDLE with BUSY, DONE, PASS, DUT_VALID, DUT_STIM, ERR_* and ERR_COUNT all 0, and clears the delay line.
REQ-035 The ENABLE edge-detect register resets to 1, so ENABLE held high across reset release does not start a test.
REQ-036 Reset mid-test abandons the test with no DONE pulse; user memory contents are not reset.

Structure
REQ-037 A shared package holds the MODE and ERR_CODE encodings, the FSM state enum, and the LW/clog2 helper constants.
REQ-038 A single sub-module bist_vec_mem (MAXLEN x 2*NCH*DW, 1 write port and 1 read port, registered read) holds the user vectors.

Verification (defaults DW=4, NCH=2, MAXLEN=256, LAT=1)
REQ-039 Counter mode, LEN=16, mask 11, loopback DUT -> BUSY for 18 cycles, DONE=1, PASS=1, ERR_COUNT=0.
REQ-040 User mode, 3 vectors loaded with entry 2 EXP ch1=4'h7 and DUT returning 4'h5 -> ERR_CODE=1, ERR_IDX=2, ERR_CH=1, ERR_EXP=7, ERR_GOT=5, ERR_COUNT=1.
REQ-041 LEN=0 (and separately MODE=11) -> DONE 1 cycle after ARM, ERR_CODE=2, DUT_VALID never high.
REQ-042 Walking-one, LEN=8, mask 01, DUT ch0 bit2 stuck-at-0, ch1 corrupted -> ERR_COUNT=2 (k=2,6), ERR_IDX=2, ERR_CH=0.
REQ-043 ENABLE low at RUN vector 5 -> DONE next cycle, ERR_CODE=3, PASS=0, DUT_VALID low that cycle.
REQ-044 RST_N pulse mid-RUN -> all outputs 0; ENABLE held high does not restart; a low-then-high ENABLE restarts and passes.
